// File: rtl/bus_arbiter_pkg.sv
// Shared types for the two-requester memory bus arbiter.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package bus_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT_I = 3'd1,
    ST_GRANT_D = 3'd2,
    ST_WAIT_I  = 3'd3,
    ST_WAIT_D  = 3'd4
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } arb_owner_t;

  // Which requester holds the bus in a given arbiter state.
  function automatic arb_owner_t owner_of(input arb_state_t s);
    case (s)
      ST_GRANT_I, ST_WAIT_I: owner_of = OWN_INSTR;
      ST_GRANT_D, ST_WAIT_D: owner_of = OWN_DATA;
      default:               owner_of = OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one memory bus, one transaction at a time.
// Latency: a request seen at edge N reaches the memory bus in cycle N+1; one IDLE cycle separates transactions.
// Backpressure: the waiting or losing requester sees waitrequest=1 until granted; the owner sees memory waitrequest.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch requester (read only)
  input  logic [ADDR_W-1:0] instr_address,
  input  logic [BE_W-1:0]   instr_byteenable,
  input  logic              instr_read,
  output logic [DATA_W-1:0] instr_readdata,
  output logic              instr_waitrequest,
  output logic              instr_readdatavalid,
  // load/store requester
  input  logic [ADDR_W-1:0] data_address,
  input  logic [BE_W-1:0]   data_byteenable,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [DATA_W-1:0] data_writedata,
  output logic [DATA_W-1:0] data_readdata,
  output logic              data_waitrequest,
  output logic              data_readdatavalid,
  // shared memory bus
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_waitrequest,
  input  logic              mem_readdatavalid,
  // current bus owner: 0 none, 1 instr, 2 data
  output logic [1:0]        debug_owner
);

  arb_state_t state;
  arb_owner_t last_owner;

  logic instr_req;
  logic data_req;

  assign instr_req = instr_read;
  // A simultaneous read+write from the data port is a write; either one is a request.
  assign data_req  = data_read | data_write;

  // Owner is a pure decode of the state register, so it never glitches with inputs.
  assign debug_owner = owner_of(state);

  // Arbitration state machine and fairness memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      last_owner <= OWN_INSTR;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_req && data_req) begin
            // Fair mode hands the tie to whoever did not finish last; otherwise data always wins.
            if ((ROUND_ROBIN != 0) && (last_owner == OWN_DATA)) begin
              state <= ST_GRANT_I;
            end else begin
              state <= ST_GRANT_D;
            end
          end else if (instr_req) begin
            state <= ST_GRANT_I;
          end else if (data_req) begin
            state <= ST_GRANT_D;
          end
        end
        ST_GRANT_I: begin
          if (!instr_req) begin
            state <= ST_IDLE;
          end else if (!mem_waitrequest) begin
            state <= ST_WAIT_I;
          end
        end
        ST_GRANT_D: begin
          if (!data_req) begin
            state <= ST_IDLE;
          end else if (!mem_waitrequest) begin
            if (data_write) begin
              // Writes have no response phase: done on acceptance.
              state      <= ST_IDLE;
              last_owner <= OWN_DATA;
            end else begin
              state <= ST_WAIT_D;
            end
          end
        end
        ST_WAIT_I: begin
          if (mem_readdatavalid) begin
            state      <= ST_IDLE;
            last_owner <= OWN_INSTR;
          end
        end
        ST_WAIT_D: begin
          if (mem_readdatavalid) begin
            state      <= ST_IDLE;
            last_owner <= OWN_DATA;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Route the owner's request to memory and the memory response back to the owner only.
  always_comb begin
    mem_address         = '0;
    mem_byteenable      = '0;
    mem_read            = 1'b0;
    mem_write           = 1'b0;
    mem_writedata       = '0;
    instr_waitrequest   = 1'b1;
    instr_readdata      = '0;
    instr_readdatavalid = 1'b0;
    data_waitrequest    = 1'b1;
    data_readdata       = '0;
    data_readdatavalid  = 1'b0;
    case (state)
      ST_GRANT_I: begin
        mem_address       = instr_address;
        mem_byteenable    = instr_byteenable;
        mem_read          = instr_read;
        instr_waitrequest = mem_waitrequest;
      end
      ST_GRANT_D: begin
        mem_address      = data_address;
        mem_byteenable   = data_byteenable;
        mem_write        = data_write;
        mem_read         = data_read & ~data_write;
        mem_writedata    = data_writedata;
        data_waitrequest = mem_waitrequest;
      end
      ST_WAIT_I: begin
        instr_readdata      = mem_readdata;
        instr_readdatavalid = mem_readdatavalid;
      end
      ST_WAIT_D: begin
        data_readdata      = mem_readdata;
        data_readdatavalid = mem_readdatavalid;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (fair and fixed priority) share stimulus; one is selected for checking.
// A transaction-level model predicts every output each cycle; directed scenarios add literal expectations.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  typedef struct packed {
    logic [31:0] mem_address;
    logic [3:0]  mem_be;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic        iwr;
    logic        irdv;
    logic [31:0] irdata;
    logic        dwr;
    logic        drdv;
    logic [31:0] drdata;
    logic [1:0]  dbg;
  } dut_out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] instr_address = '0;
  logic [3:0]  instr_byteenable = 4'hF;
  logic        instr_read = 1'b0;
  logic [31:0] data_address = '0;
  logic [3:0]  data_byteenable = 4'hF;
  logic        data_read = 1'b0;
  logic        data_write = 1'b0;
  logic [31:0] data_writedata = '0;
  logic [31:0] m_rdata = '0;
  logic        m_wreq = 1'b0;
  logic        m_rdv = 1'b0;

  dut_out_t o_rr, o_fp, cur;
  assign cur = sel ? o_fp : o_rr;

  bus_arbiter #(.ROUND_ROBIN(1)) dut_rr (
    .clk(clk), .rst(rst),
    .instr_address(instr_address), .instr_byteenable(instr_byteenable), .instr_read(instr_read),
    .instr_readdata(o_rr.irdata), .instr_waitrequest(o_rr.iwr), .instr_readdatavalid(o_rr.irdv),
    .data_address(data_address), .data_byteenable(data_byteenable), .data_read(data_read),
    .data_write(data_write), .data_writedata(data_writedata),
    .data_readdata(o_rr.drdata), .data_waitrequest(o_rr.dwr), .data_readdatavalid(o_rr.drdv),
    .mem_address(o_rr.mem_address), .mem_byteenable(o_rr.mem_be), .mem_read(o_rr.mem_read),
    .mem_write(o_rr.mem_write), .mem_writedata(o_rr.mem_wdata), .mem_readdata(m_rdata),
    .mem_waitrequest(m_wreq), .mem_readdatavalid(m_rdv), .debug_owner(o_rr.dbg)
  );

  bus_arbiter #(.ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .rst(rst),
    .instr_address(instr_address), .instr_byteenable(instr_byteenable), .instr_read(instr_read),
    .instr_readdata(o_fp.irdata), .instr_waitrequest(o_fp.iwr), .instr_readdatavalid(o_fp.irdv),
    .data_address(data_address), .data_byteenable(data_byteenable), .data_read(data_read),
    .data_write(data_write), .data_writedata(data_writedata),
    .data_readdata(o_fp.drdata), .data_waitrequest(o_fp.dwr), .data_readdatavalid(o_fp.drdv),
    .mem_address(o_fp.mem_address), .mem_byteenable(o_fp.mem_be), .mem_read(o_fp.mem_read),
    .mem_write(o_fp.mem_write), .mem_writedata(o_fp.mem_wdata), .mem_readdata(m_rdata),
    .mem_waitrequest(m_wreq), .mem_readdatavalid(m_rdv), .debug_owner(o_fp.dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // ---------------- memory responder ----------------
  int          mem_wait = 0;
  bit          mem_respond = 1'b1;
  bit          inject_rdv = 1'b0;
  logic [31:0] rd_value = 32'hDEADBEEF;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  initial begin
    int   wcnt;
    logic acc_rd;
    wcnt = 0;
    forever begin
      @(negedge clk);
      acc_rd = cur.mem_read && !m_wreq && mem_respond;
      if (cur.mem_write && !m_wreq) begin
        wr_addr_q.push_back(cur.mem_address);
        wr_data_q.push_back(cur.mem_wdata);
      end
      @(posedge clk);
      #2;
      m_rdv   = acc_rd || inject_rdv;
      m_rdata = rd_value;
      if (cur.mem_read || cur.mem_write) begin
        if (wcnt < mem_wait) begin
          m_wreq = 1'b1;
          wcnt++;
        end else begin
          m_wreq = 1'b0;
        end
      end else begin
        m_wreq = 1'b0;
        wcnt   = 0;
      end
    end
  end

  // ---------------- behavioural model and per-cycle compare ----------------
  // Model: who owns the bus (0 none, 1 instr, 2 data), whether the owner's read was accepted,
  // and who completed last. Outputs follow directly from those facts.
  initial begin
    int   m_own, m_last, n_own, n_last, rr;
    bit   m_iss, n_iss;
    logic ireq, dreq, oreq;
    logic e_rd, e_wr, e_iwr, e_dwr, e_irdv, e_drdv;
    m_own = 0; m_last = 1; m_iss = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_own = 0; m_iss = 1'b0; m_last = 1;
      end
      rr = sel ? 0 : 1;
      e_rd = 1'b0; e_wr = 1'b0; e_iwr = 1'b1; e_dwr = 1'b1; e_irdv = 1'b0; e_drdv = 1'b0;
      if (m_own == 1 && !m_iss) begin
        e_rd  = instr_read;
        e_iwr = m_wreq;
      end
      if (m_own == 2 && !m_iss) begin
        e_wr  = data_write;
        e_rd  = data_read && !data_write;
        e_dwr = m_wreq;
      end
      if (m_iss && m_own == 1) e_irdv = m_rdv;
      if (m_iss && m_own == 2) e_drdv = m_rdv;
      check_i("model_debug_owner", int'(cur.dbg), m_own);
      check_b("model_mem_read", cur.mem_read, e_rd);
      check_b("model_mem_write", cur.mem_write, e_wr);
      check_b("model_instr_waitrequest", cur.iwr, e_iwr);
      check_b("model_data_waitrequest", cur.dwr, e_dwr);
      check_b("model_instr_readdatavalid", cur.irdv, e_irdv);
      check_b("model_data_readdatavalid", cur.drdv, e_drdv);
      if (e_rd || e_wr) check_w("model_mem_address", cur.mem_address, (m_own == 1) ? instr_address : data_address);
      if (e_wr) check_w("model_mem_writedata", cur.mem_wdata, data_writedata);
      if (e_irdv) check_w("model_instr_readdata", cur.irdata, m_rdata);
      if (e_drdv) check_w("model_data_readdata", cur.drdata, m_rdata);
      // next cycle
      n_own = m_own; n_iss = m_iss; n_last = m_last;
      if (rst) begin
        ireq = instr_read;
        dreq = data_read || data_write;
        if (m_own == 0) begin
          if (ireq && dreq) n_own = (rr == 1 && m_last == 2) ? 1 : 2;
          else if (ireq)    n_own = 1;
          else if (dreq)    n_own = 2;
        end else if (m_iss) begin
          if (m_rdv) begin
            n_last = m_own; n_own = 0; n_iss = 1'b0;
          end
        end else begin
          oreq = (m_own == 1) ? ireq : dreq;
          if (!oreq) n_own = 0;
          else if (!m_wreq) begin
            if (m_own == 2 && data_write) begin
              n_own = 0; n_last = 2;
            end else begin
              n_iss = 1'b1;
            end
          end
        end
      end
      @(posedge clk);
      m_own = n_own; m_iss = n_iss; m_last = n_last;
    end
  end

  // Counts cycles where instr owned the bus while the data port was streaming requests.
  bit data_busy = 1'b0;
  int busy_instr_grants = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (data_busy && cur.dbg == 2'd1) busy_instr_grants++;
    end
  end

  // ---------------- agent tasks ----------------
  int order_log[$];

  task automatic instr_txn(input logic [31:0] addr, output logic [31:0] rdata, output int ok);
    instr_address = addr;
    instr_read    = 1'b1;
    rdata = '0;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!cur.iwr) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    instr_read = 1'b0;
    if (ok == 0) begin fail_timeout("instr_accept"); return; end
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cur.irdv) begin ok = 1; rdata = cur.irdata; break; end
    end
    if (ok == 1) order_log.push_back(1);
    else fail_timeout("instr_readdatavalid");
  endtask

  task automatic data_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic rd, input logic wr,
                          output int waits, output logic saw_rd, output logic saw_wr, output int ok);
    data_address   = addr;
    data_writedata = wdata;
    data_read      = rd;
    data_write     = wr;
    waits = 0; saw_rd = 1'b0; saw_wr = 1'b0; ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cur.dbg == 2'd2) begin
        check_w("data_addr_stable", cur.mem_address, addr);
        if (cur.dwr) waits++;
        else begin
          ok = 1; saw_rd = cur.mem_read; saw_wr = cur.mem_write;
          break;
        end
      end
    end
    @(posedge clk); #1;
    data_read  = 1'b0;
    data_write = 1'b0;
    if (ok == 0) begin fail_timeout("data_accept"); return; end
    if (wr) begin
      order_log.push_back(2);
    end else begin
      ok = 0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (cur.drdv) begin ok = 1; break; end
      end
      if (ok == 1) order_log.push_back(2);
      else fail_timeout("data_readdatavalid");
    end
  endtask

  task automatic do_reset(input logic s);
    @(posedge clk); #1;
    rst = 1'b0;
    sel = s;
    instr_read = 1'b0; data_read = 1'b0; data_write = 1'b0;
    mem_wait = 0; mem_respond = 1'b1; inject_rdv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [31:0] rd;
    int ok, w;
    logic sr, sw;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_i("reset_debug_owner", int'(cur.dbg), 0);
    check_b("reset_instr_waitrequest", cur.iwr, 1'b1);
    check_b("reset_data_waitrequest", cur.dwr, 1'b1);
    check_b("reset_mem_read", cur.mem_read, 1'b0);

    // Lone instruction read, zero-wait memory
    @(posedge clk); #1;
    instr_address = 32'h0000_0010;
    instr_read    = 1'b1;
    @(negedge clk);
    check_b("t29_no_comb_forward", cur.mem_read, 1'b0);
    @(negedge clk);
    check_b("t29_mem_read", cur.mem_read, 1'b1);
    check_w("t29_mem_address", cur.mem_address, 32'h0000_0010);
    check_b("t29_instr_wr", cur.iwr, 1'b0);
    @(posedge clk); #1;
    instr_read = 1'b0;
    @(negedge clk);
    check_b("t29_instr_rdv", cur.irdv, 1'b1);
    check_w("t29_instr_rdata", cur.irdata, 32'hDEADBEEF);
    check_b("t29_data_rdv", cur.drdv, 1'b0);
    @(negedge clk);
    check_i("t29_back_to_idle", int'(cur.dbg), 0);

    // Tie in fair mode: data first, then instr, then data again
    do_reset(1'b0);
    order_log.delete(); wr_addr_q.delete(); wr_data_q.delete();
    fork
      instr_txn(32'h0, rd, ok);
      begin
        int w2, ok2;
        logic sr2, sw2;
        data_txn(32'h100, 32'h12345678, 1'b0, 1'b1, w2, sr2, sw2, ok2);
        data_txn(32'h104, 32'hCAFEF00D, 1'b0, 1'b1, w2, sr2, sw2, ok2);
      end
    join
    check_i("t30_order_len", order_log.size(), 3);
    if (order_log.size() == 3) begin
      check_i("t30_first_data", order_log[0], 2);
      check_i("t30_then_instr", order_log[1], 1);
      check_i("t30_then_data", order_log[2], 2);
    end
    check_w("t30_instr_rdata", rd, 32'hDEADBEEF);
    check_i("t30_writes", wr_addr_q.size(), 2);
    if (wr_addr_q.size() > 0) begin
      check_w("t30_wr_addr", wr_addr_q[0], 32'h100);
      check_w("t30_wr_data", wr_data_q[0], 32'h12345678);
    end

    // Fixed priority: streaming data starves instr until it stops
    do_reset(1'b1);
    busy_instr_grants = 0;
    fork
      begin
        logic [31:0] r3;
        int ok3;
        instr_txn(32'h80, r3, ok3);
      end
      begin
        int w3, ok4, lat;
        logic sr3, sw3;
        data_busy = 1'b1;
        for (int k = 0; k < 5; k++) data_txn(32'h400 + k * 4, k, 1'b0, 1'b1, w3, sr3, sw3, ok4);
        data_busy = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
          @(negedge clk);
          if (cur.dbg == 2'd1) begin lat = i; break; end
        end
        check_i("t31_instr_latency", lat, 2);
      end
    join
    check_i("t31_instr_grants_while_busy", busy_instr_grants, 0);

    // Memory stalls three cycles in data grant
    do_reset(1'b0);
    mem_wait = 3;
    fork
      data_txn(32'h300, 32'h11112222, 1'b0, 1'b1, w, sr, sw, ok);
      begin
        logic [31:0] r5;
        int ok5;
        @(posedge clk); #1;
        instr_txn(32'h20, r5, ok5);
      end
    join
    check_i("t32_data_wait_cycles", w, 3);
    mem_wait = 0;

    // Reset during WAIT_I, late readdatavalid afterwards
    do_reset(1'b0);
    mem_respond   = 1'b0;
    instr_address = 32'h40;
    instr_read    = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!cur.iwr) begin ok = 1; break; end
    end
    if (ok == 0) fail_timeout("t33_accept");
    @(posedge clk); #1;
    instr_read = 1'b0;
    @(negedge clk);
    check_i("t33_in_wait", int'(cur.dbg), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_i("t33_reset_owner", int'(cur.dbg), 0);
    check_b("t33_reset_mem_read", cur.mem_read, 1'b0);
    check_b("t33_reset_instr_wr", cur.iwr, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    mem_respond = 1'b1;
    inject_rdv  = 1'b1;
    @(negedge clk);
    check_b("t33_late_instr_rdv", cur.irdv, 1'b0);
    check_b("t33_late_data_rdv", cur.drdv, 1'b0);
    check_i("t33_owner_after", int'(cur.dbg), 0);
    @(posedge clk); #1;
    inject_rdv = 1'b0;

    // Data read and write together is a write
    wr_addr_q.delete(); wr_data_q.delete();
    data_txn(32'h200, 32'hA5A5A5A5, 1'b1, 1'b1, w, sr, sw, ok);
    check_b("t34_mem_write", sw, 1'b1);
    check_b("t34_mem_read", sr, 1'b0);
    @(negedge clk);
    check_i("t34_no_wait_d", int'(cur.dbg), 0);
    check_i("t34_write_seen", wr_addr_q.size(), 1);
    if (wr_addr_q.size() > 0) check_w("t34_wr_addr", wr_addr_q[0], 32'h200);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
